mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The port list SHALL be as follows, as name, direction, width, meaning:
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-low reset.
- newinstr  in  1  new-instruction strobe, sampled on the rising clock edge.
- instrword  in  32  instruction word; valid whenever newinstr is high.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse in the final state of an instruction.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- dropped  out  1  sticky flag: a newinstr rising edge arrived while busy.
- instr_q  out  32  captured instruction register.
- state  out  3  debug state code.
- regwrite, regdst, alusrc, memread, memwrite, memtoreg  out  1 each  datapath controls.
- aluop  out  3  ALU operation code.

Function
REQ-003 newinstr SHALL be edge-detected with one register; an edge is newinstr=1 while the previous sampled value was 0, and a level held high SHALL issue one instruction only.
REQ-004 States SHALL be encoded as IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4, with all other codes returning to IDLE.
REQ-005 In IDLE, an edge SHALL load instr_q from instrword and move to DECODE on the next cycle.
REQ-006 An edge seen in any non-IDLE state SHALL be ignored and SHALL set dropped.
REQ-007 DECODE SHALL classify instr_q[31:26] as follows:
- 35 (lw) -> EXEC.
- 43 (sw) -> EXEC.
- 0 (R-type) with funct 32/34/36/37/42 -> EXEC.
- anything else -> IDLE, with illegal pulsed in that DECODE cycle.
REQ-008 The sequences SHALL be:
- lw: EXEC -> MEM -> WB -> IDLE.
- sw: EXEC -> MEM -> IDLE.
- R-type: EXEC -> WB -> IDLE.
REQ-009 Control outputs SHALL be Moore, decoded from state and instr_q only; every control is 0 unless listed:
- EXEC: alusrc=1 for lw/sw.
- MEM: memread=1 for lw; memwrite=1 for sw.
- WB: regwrite=1; memtoreg=1 for lw; regdst=1 for R-type.
REQ-010 aluop SHALL be 000 (ADD) for lw/sw. For R-type it SHALL follow funct:
- 32 -> 000 (ADD)
- 34 -> 001 (SUB)
- 36 -> 010 (AND)
- 37 -> 011 (OR)
- 42 -> 100 (SLT)
REQ-011 aluop SHALL be held constant from DECODE through the final state.
REQ-012 done SHALL be high exactly in the WB cycle for lw/R-type, and in the MEM cycle for sw.
REQ-013 Latency SHALL be counted from the capture edge to the done cycle: lw 4 cycles, sw 3, R-type 3.
REQ-014 An edge arriving in the done cycle SHALL be dropped; the next instruction is accepted in IDLE only.
REQ-015 dropped SHALL clear only on reset.

Reset
REQ-016 reset=0 SHALL asynchronously force:
- state, busy, done, illegal, dropped, all controls, aluop and instr_q to 0;
- the newinstr edge register to 1, so that a strobe held high through reset does not issue.
REQ-017 A reset in mid-instruction SHALL abort the instruction with no regwrite/memwrite after reset deasserts.
REQ-018 Operation SHALL resume on the first rising edge after reset returns to 1.

Configuration
REQ-019 With MIPS_CTRL_ADDI_EN defined, opcode 8 (addi) SHALL be legal with the sequence EXEC(alusrc=1, aluop=000) -> WB(regwrite=1, regdst=0) -> IDLE, a latency of 3 cycles, and done in WB.
REQ-020 Without MIPS_CTRL_ADDI_EN defined, opcode 8 SHALL be illegal per REQ-007.

Verification
REQ-021 lw $1,0($0): instrword 0x8C010000 with a 1-cycle newinstr -> states 1,2,3,4 follow capture, and the expected controls are:
- EXEC: alusrc=1.
- MEM: memread=1.
- WB: regwrite=1, memtoreg=1, done=1.
- busy low on the next cycle.
REQ-022 sw $5,3($0): 0xAC050003 -> memwrite=1 and done=1 in MEM, regwrite never 1, then IDLE.
REQ-023 add $4,$1,$2 (0x00222020) then sub $5,$4,$3 (0x00832822), back-to-back after each done:
- add: aluop 000, with regdst=1 and regwrite=1 in WB.
- sub: aluop 001.
- dropped stays 0.
REQ-024 The following SHALL each produce illegal=1 for one cycle, no control asserted, and return to IDLE:
- 0xFC000000;
- 0x00000000 (funct 0);
- 0x20010005 with MIPS_CTRL_ADDI_EN undefined.
With the macro defined, 0x20010005 SHALL instead complete in 3 cycles with regwrite=1 and regdst=0.
REQ-025 Robustness checks:
- newinstr edge during EXEC of an lw -> dropped=1, and the lw completes unchanged.
- newinstr held high for 5 cycles -> exactly one instruction issues.
- reset pulled low during MEM of an sw -> memwrite=0 immediately and state=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM (lw/sw/R-type ALU ops) with registered Moore outputs.
// Optional: define MIPS_CTRL_ADDI_EN to accept opcode 8 (addi).
module mips_multicycle_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        newinstr,
    input  logic [31:0] instrword,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        dropped,
    output logic [31:0] instr_q,
    output logic [2:0]  state,
    output logic        regwrite,
    output logic        regdst,
    output logic        alusrc,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic [2:0]  aluop
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {K_LW, K_SW, K_RTYPE, K_ADDI, K_BAD} kind_t;

    state_t      cur, nxt;
    logic [31:0] nxt_instr;
    logic        prev_strobe;
    logic        strobe_edge;
    kind_t       kind, nkind;

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        case (op)
            6'd35: k = K_LW;
            6'd43: k = K_SW;
            6'd0: begin
                case (fn)
                    6'd32, 6'd34, 6'd36, 6'd37, 6'd42: k = K_RTYPE;
                    default:                           k = K_BAD;
                endcase
            end
`ifdef MIPS_CTRL_ADDI_EN
            6'd8:  k = K_ADDI;
`endif
            default: k = K_BAD;
        endcase
        return k;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        logic [2:0] a;
        a = 3'b000;
        if (op == 6'd0) begin
            case (fn)
                6'd34:   a = 3'b001;
                6'd36:   a = 3'b010;
                6'd37:   a = 3'b011;
                6'd42:   a = 3'b100;
                default: a = 3'b000;
            endcase
        end
        return a;
    endfunction

    always_comb begin
        strobe_edge = newinstr & ~prev_strobe;
        nxt_instr   = instr_q;
        nxt         = cur;
        kind        = classify(instr_q[31:26], instr_q[5:0]);
        case (cur)
            IDLE: begin
                if (strobe_edge) begin
                    nxt_instr = instrword;
                    nxt       = DECODE;
                end
            end
            DECODE:  nxt = (kind == K_BAD) ? IDLE : EXEC;
            EXEC:    nxt = (kind == K_LW || kind == K_SW) ? MEM : WB;
            MEM:     nxt = (kind == K_LW) ? WB : IDLE;
            WB:      nxt = IDLE;
            default: nxt = IDLE;
        endcase
        nkind = classify(nxt_instr[31:26], nxt_instr[5:0]);
    end

    // Outputs are registered from the next state so they stay pure functions of state and instr_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur         <= IDLE;
            prev_strobe <= 1'b1;
            instr_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            dropped     <= 1'b0;
            regwrite    <= 1'b0;
            regdst      <= 1'b0;
            alusrc      <= 1'b0;
            memread     <= 1'b0;
            memwrite    <= 1'b0;
            memtoreg    <= 1'b0;
            aluop       <= '0;
        end else begin
            cur         <= nxt;
            prev_strobe <= newinstr;
            instr_q     <= nxt_instr;
            if (strobe_edge && cur != IDLE)
                dropped <= 1'b1;
            busy     <= (nxt != IDLE);
            done     <= (nxt == WB) || (nxt == MEM && nkind == K_SW);
            illegal  <= (nxt == DECODE) && (nkind == K_BAD);
            alusrc   <= (nxt == EXEC) && (nkind == K_LW || nkind == K_SW || nkind == K_ADDI);
            memread  <= (nxt == MEM) && (nkind == K_LW);
            memwrite <= (nxt == MEM) && (nkind == K_SW);
            regwrite <= (nxt == WB);
            memtoreg <= (nxt == WB) && (nkind == K_LW);
            regdst   <= (nxt == WB) && (nkind == K_RTYPE);
            aluop    <= (nxt != IDLE && nkind != K_BAD) ? alu_of(nxt_instr[31:26], nxt_instr[5:0]) : '0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-instruction schedule model plus literal pins.
module tb_mips_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        nin;
    logic [31:0] instrword;
    logic        busy, done, illegal, dropped;
    logic [31:0] instr_q;
    logic [2:0]  state;
    logic        regwrite, regdst, alusrc, memread, memwrite, memtoreg;
    logic [2:0]  aluop;

`ifdef MIPS_CTRL_ADDI_EN
    localparam bit ADDI = 1'b1;
`else
    localparam bit ADDI = 1'b0;
`endif

    mips_multicycle_ctrl dut (
        .clock(clk), .reset(rst_n), .newinstr(nin), .instrword(instrword),
        .busy(busy), .done(done), .illegal(illegal), .dropped(dropped),
        .instr_q(instr_q), .state(state), .regwrite(regwrite), .regdst(regdst),
        .alusrc(alusrc), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .aluop(aluop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic bz, dn, il, rw, rd, as, mr, mw, mt;
        logic [2:0] ao;
    } rec_t;

    rec_t        q[$];
    rec_t        cur   = '0;
    logic        m_drop = 1'b0;
    logic [31:0] m_instr = '0;
    logic        m_prev = 1'b1;
    logic        m_edge;
    int          n_vec = 0;
    int          n_bad = 0;

    // One record per cycle the instruction occupies, from the instruction's class.
    function automatic void make_sched(input logic [31:0] w);
        int   op, fn, path[$];
        bit   lw, sw, r, ad, legal;
        logic [2:0] ao;
        rec_t rc;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        lw = (op == 35);
        sw = (op == 43);
        r  = (op == 0) && (fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 42);
        ad = ADDI && (op == 8);
        legal = lw || sw || r || ad;
        ao = !r ? 3'd0 : fn == 32 ? 3'd0 : fn == 34 ? 3'd1 : fn == 36 ? 3'd2 : fn == 37 ? 3'd3 : 3'd4;
        if (!legal)  path = '{1};
        else if (lw) path = '{1, 2, 3, 4};
        else if (sw) path = '{1, 2, 3};
        else         path = '{1, 2, 4};
        for (int i = 0; i < path.size(); i++) begin
            rc    = '0;
            rc.st = 3'(path[i]);
            rc.bz = 1'b1;
            rc.ao = legal ? ao : 3'd0;
            rc.il = !legal;
            rc.dn = legal && (i == path.size() - 1);
            rc.as = (path[i] == 2) && (lw || sw || ad);
            rc.mr = (path[i] == 3) && lw;
            rc.mw = (path[i] == 3) && sw;
            rc.rw = (path[i] == 4);
            rc.mt = (path[i] == 4) && lw;
            rc.rd = (path[i] == 4) && r;
            q.push_back(rc);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur     = '0;
            m_drop  = 1'b0;
            m_instr = '0;
            m_prev  = 1'b1;
        end else begin
            m_edge = nin && !m_prev;
            m_prev = nin;
            if (cur.bz) begin
                if (m_edge) m_drop = 1'b1;
                cur = (q.size() != 0) ? q.pop_front() : '0;
            end else if (m_edge) begin
                m_instr = instrword;
                make_sched(instrword);
                cur = q.pop_front();
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [31:0] w, input int len);
        @(negedge clk);
        instrword = w;
        nin = 1'b1;
        repeat (len) @(negedge clk);
        nin = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        nin = 1'b0;
        instrword = '0;
        #3 rst_n = 1'b0;
        nin = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {29'd0, state}, 32'd0);
        check("reset_outs", {busy, done, illegal, dropped, regwrite, memwrite, aluop}, 32'd0);
        check("reset_instr_q", instr_q, 32'd0);
        fork
            forever begin
                @(negedge clk);
                check("outs", {17'd0, state, busy, done, illegal, regwrite, regdst, alusrc,
                               memread, memwrite, memtoreg, aluop}, {17'd0, cur});
                check("dropped", {31'd0, dropped}, {31'd0, m_drop});
                check("instr_q", instr_q, m_instr);
            end
        join_none
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("held_thru_reset_busy", {31'd0, busy}, 32'd0);
        nin = 1'b0;

        // lw $1,0($0)
        issue(32'h8C010000, 1);
        check("lw_decode", {29'd0, state}, 32'd1);
        @(negedge clk);
        check("lw_exec", {state, alusrc}, {3'd2, 1'b1});
        @(negedge clk);
        check("lw_mem", {state, memread}, {3'd3, 1'b1});
        @(negedge clk);
        check("lw_wb", {state, regwrite, memtoreg, done}, {3'd4, 3'b111});
        @(negedge clk);
        check("lw_idle", {31'd0, busy}, 32'd0);

        // sw $5,3($0)
        issue(32'hAC050003, 1);
        repeat (2) @(negedge clk);
        check("sw_mem", {state, memwrite, done, regwrite}, {3'd3, 3'b110});
        @(negedge clk);
        check("sw_idle", {29'd0, state}, 32'd0);

        // add then sub, each issued once the previous one is back in IDLE
        issue(32'h00222020, 1);
        check("add_aluop", {29'd0, aluop}, 32'd0);
        repeat (2) @(negedge clk);
        check("add_wb", {state, regdst, regwrite}, {3'd4, 2'b11});
        issue(32'h00832822, 1);
        check("sub_aluop", {29'd0, aluop}, 32'd1);
        repeat (3) @(negedge clk);
        check("no_drop_b2b", {31'd0, dropped}, 32'd0);

        issue(32'hFC000000, 1);
        check("ill_op", {illegal, regwrite, memwrite, alusrc}, 32'b1000);
        @(negedge clk);
        check("ill_op_idle", {29'd0, illegal, busy, 1'b0}, 32'd0);
        issue(32'h00000000, 1);
        check("ill_funct", {31'd0, illegal}, 32'd1);
        @(negedge clk);
        issue(32'h20010005, 1);
        check("addi_decode", {31'd0, illegal}, {31'd0, !ADDI});
        repeat (2) @(negedge clk);
        if (ADDI) check("addi_wb", {state, regwrite, regdst, done}, {3'd4, 3'b101});
        else      check("addi_ill_idle", {29'd0, state}, 32'd0);
        repeat (2) @(negedge clk);

        // strobe edge sampled during EXEC of an lw
        issue(32'h8C010000, 1);
        @(negedge clk);
        nin = 1'b1;
        @(negedge clk);
        nin = 1'b0;
        check("drop_in_exec", {state, dropped}, {3'd3, 1'b1});
        repeat (3) @(negedge clk);

        // strobe held high for 5 cycles
        issue(32'h00222024, 5);
        check("held_high_idle", {29'd0, state}, 32'd0);
        repeat (3) @(negedge clk);

        // reset asserted while an sw is in MEM
        issue(32'hAC050003, 1);
        repeat (2) @(negedge clk);
        check("sw_mem_pre_reset", {31'd0, memwrite}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_mem", {state, memwrite, dropped}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_idle", {29'd0, state}, 32'd0);
        issue(32'h00A33024, 1);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
